// File: rtl/sdram_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : sdram_ctrl_fsm
// Description : SDRAM controller sequencing core: power-up init FSM, work FSM
//               for burst write / burst read / auto-refresh, per-state cycle
//               counter, refresh scheduler and completion pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_ctrl_fsm #(
    parameter int T_INIT     = 10000,
    parameter int TRP        = 3,
    parameter int TRFC       = 7,
    parameter int TMRD       = 2,
    parameter int TRCD       = 3,
    parameter int TCL        = 3,
    parameter int TDAL       = 3,
    parameter int REF_PERIOD = 750
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sdram_wr_req,
    input  logic       sdram_rd_req,
    input  logic [9:0] sdwr_byte,
    input  logic [9:0] sdrd_byte,
    output logic       sdram_wr_ack,
    output logic       sdram_rd_ack,
    output logic [3:0] init_state,
    output logic [3:0] work_state,
    output logic       sys_r_wn,
    output logic [9:0] cnt_clk,
    output logic       sdram_init_done,
    output logic       sdram_busy
);

    typedef enum logic [3:0] {
        I_NOP  = 4'd0,
        I_PRE  = 4'd1,
        I_TRP  = 4'd2,
        I_AR1  = 4'd3,
        I_TRF1 = 4'd4,
        I_AR2  = 4'd5,
        I_TRF2 = 4'd6,
        I_MRS  = 4'd7,
        I_TMRD = 4'd8,
        I_DONE = 4'd9
    } init_state_t;

    typedef enum logic [3:0] {
        W_IDLE   = 4'd0,
        W_ACTIVE = 4'd1,
        W_TRCD   = 4'd2,
        W_READ   = 4'd3,
        W_CL     = 4'd4,
        W_RD     = 4'd5,
        W_WRITE  = 4'd6,
        W_WD     = 4'd7,
        W_TDAL   = 4'd8,
        W_AR     = 4'd9,
        W_TRFC   = 4'd10
    } work_state_t;

    // Exit points of the timed states: a state held N cycles leaves when cnt_clk == N-1.
    localparam logic [13:0] C_INIT_LAST = 14'(T_INIT - 1);
    localparam logic [9:0]  C_TRP_LAST  = 10'(TRP - 1);
    localparam logic [9:0]  C_TRFC_LAST = 10'(TRFC - 1);
    localparam logic [9:0]  C_TMRD_LAST = 10'(TMRD - 1);
    localparam logic [9:0]  C_TRCD_LAST = 10'(TRCD - 1);
    localparam logic [9:0]  C_TCL_LAST  = 10'(TCL - 1);
    localparam logic [9:0]  C_TDAL_LAST = 10'(TDAL - 1);
    localparam logic [15:0] C_REF_LAST  = 16'(REF_PERIOD - 1);
    localparam logic [9:0]  C_CNT_MAX   = 10'h3FF;

    init_state_t r_init_state, w_init_next;
    work_state_t r_work_state, w_work_next;
    logic [9:0]  r_cnt_clk;
    logic [13:0] r_init_cnt;
    logic [15:0] r_ref_cnt;
    logic        r_ref_pending;
    logic        r_sys_r_wn;
    logic [8:0]  r_burst_len;

    logic        w_init_done;
    logic        w_state_change;
    logic        w_start_wr;
    logic        w_start_rd;
    logic        w_start_ref;
    logic        w_ref_wrap;
    logic [9:0]  w_burst_last;

    // Map a requested byte count onto the legal 1..256 burst range.
    function automatic logic [8:0] clamp_len(input logic [9:0] req_len);
        logic [8:0] len;
        if (req_len == 10'd0)
            len = 9'd1;
        else if (req_len > 10'd256)
            len = 9'd256;
        else
            len = req_len[8:0];
        return len;
    endfunction

    assign w_init_done  = (r_init_state == I_DONE);
    assign w_burst_last = {1'b0, r_burst_len} - 10'd1;
    assign w_ref_wrap   = w_init_done && (r_ref_cnt == C_REF_LAST);

    always_comb begin
        w_init_next = r_init_state;
        case (r_init_state)
            I_NOP:   if (r_init_cnt == C_INIT_LAST) w_init_next = I_PRE;
            I_PRE:   w_init_next = I_TRP;
            I_TRP:   if (r_cnt_clk == C_TRP_LAST)  w_init_next = I_AR1;
            I_AR1:   w_init_next = I_TRF1;
            I_TRF1:  if (r_cnt_clk == C_TRFC_LAST) w_init_next = I_AR2;
            I_AR2:   w_init_next = I_TRF2;
            I_TRF2:  if (r_cnt_clk == C_TRFC_LAST) w_init_next = I_MRS;
            I_MRS:   w_init_next = I_TMRD;
            I_TMRD:  if (r_cnt_clk == C_TMRD_LAST) w_init_next = I_DONE;
            I_DONE:  w_init_next = I_DONE;
            default: w_init_next = I_NOP;
        endcase
    end

    always_comb begin
        w_work_next = r_work_state;
        w_start_wr  = 1'b0;
        w_start_rd  = 1'b0;
        w_start_ref = 1'b0;
        case (r_work_state)
            W_IDLE: begin
                // Refresh outranks traffic; write outranks read.
                if (w_init_done) begin
                    if (r_ref_pending) begin
                        w_work_next = W_AR;
                        w_start_ref = 1'b1;
                    end else if (sdram_wr_req) begin
                        w_work_next = W_ACTIVE;
                        w_start_wr  = 1'b1;
                    end else if (sdram_rd_req) begin
                        w_work_next = W_ACTIVE;
                        w_start_rd  = 1'b1;
                    end
                end
            end
            W_ACTIVE: w_work_next = W_TRCD;
            W_TRCD:   if (r_cnt_clk == C_TRCD_LAST) w_work_next = r_sys_r_wn ? W_READ : W_WRITE;
            W_WRITE:  w_work_next = W_WD;
            W_WD:     if (r_cnt_clk == w_burst_last) w_work_next = W_TDAL;
            W_TDAL:   if (r_cnt_clk == C_TDAL_LAST) w_work_next = W_IDLE;
            W_READ:   w_work_next = W_CL;
            W_CL:     if (r_cnt_clk == C_TCL_LAST)  w_work_next = W_RD;
            W_RD:     if (r_cnt_clk == w_burst_last) w_work_next = W_IDLE;
            W_AR:     w_work_next = W_TRFC;
            W_TRFC:   if (r_cnt_clk == C_TRFC_LAST) w_work_next = W_IDLE;
            default:  w_work_next = W_IDLE;
        endcase
    end

    assign w_state_change = (w_init_next != r_init_state) || (w_work_next != r_work_state);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_init_state <= I_NOP;
            r_work_state <= W_IDLE;
            r_cnt_clk    <= '0;
        end else begin
            r_init_state <= w_init_next;
            r_work_state <= w_work_next;
            if (w_state_change)
                r_cnt_clk <= '0;
            else if (r_cnt_clk != C_CNT_MAX)
                r_cnt_clk <= r_cnt_clk + 10'd1;
        end
    end

    // Power-up wait exceeds cnt_clk range, so it has a dedicated wider counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_init_cnt <= '0;
        else if (r_init_state == I_NOP)
            r_init_cnt <= r_init_cnt + 14'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sys_r_wn  <= 1'b0;
            r_burst_len <= 9'd1;
        end else if (w_start_wr) begin
            r_sys_r_wn  <= 1'b0;
            r_burst_len <= clamp_len(sdwr_byte);
        end else if (w_start_rd) begin
            r_sys_r_wn  <= 1'b1;
            r_burst_len <= clamp_len(sdrd_byte);
        end
    end

    // A wrap coinciding with refresh entry stays pending for the next interval.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ref_cnt     <= '0;
            r_ref_pending <= 1'b0;
        end else begin
            if (w_init_done)
                r_ref_cnt <= w_ref_wrap ? 16'd0 : r_ref_cnt + 16'd1;
            if (w_ref_wrap)
                r_ref_pending <= 1'b1;
            else if (w_start_ref)
                r_ref_pending <= 1'b0;
        end
    end

    assign sdram_wr_ack    = (r_work_state == W_TDAL) && (w_work_next == W_IDLE);
    assign sdram_rd_ack    = (r_work_state == W_RD)   && (w_work_next == W_IDLE);
    assign init_state      = r_init_state;
    assign work_state      = r_work_state;
    assign sys_r_wn        = r_sys_r_wn;
    assign cnt_clk         = r_cnt_clk;
    assign sdram_init_done = w_init_done;
    assign sdram_busy      = !(w_init_done && (r_work_state == W_IDLE) && !r_ref_pending);

endmodule
`default_nettype wire

// File: tb/tb_sdram_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_ctrl_fsm
// Description : Scoreboard bench for sdram_ctrl_fsm: stimulus queues expected
//               state segments and acks, a negedge monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_ctrl_fsm;

    localparam logic [3:0] W_IDLE = 4'd0, W_ACTIVE = 4'd1, W_TRCD = 4'd2, W_READ = 4'd3,
                           W_CL = 4'd4, W_RD = 4'd5, W_WRITE = 4'd6, W_WD = 4'd7,
                           W_TDAL = 4'd8, W_AR = 4'd9, W_TRFC = 4'd10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sdram_wr_req, sdram_rd_req;
    logic [9:0] sdwr_byte, sdrd_byte;
    logic       sdram_wr_ack, sdram_rd_ack;
    logic [3:0] init_state, work_state;
    logic       sys_r_wn;
    logic [9:0] cnt_clk;
    logic       sdram_init_done, sdram_busy;

    always #5 clk = ~clk;

    sdram_ctrl_fsm #(
        .T_INIT     (20),
        .REF_PERIOD (100)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .sdram_wr_req    (sdram_wr_req),
        .sdram_rd_req    (sdram_rd_req),
        .sdwr_byte       (sdwr_byte),
        .sdrd_byte       (sdrd_byte),
        .sdram_wr_ack    (sdram_wr_ack),
        .sdram_rd_ack    (sdram_rd_ack),
        .init_state      (init_state),
        .work_state      (work_state),
        .sys_r_wn        (sys_r_wn),
        .cnt_clk         (cnt_clk),
        .sdram_init_done (sdram_init_done),
        .sdram_busy      (sdram_busy)
    );

    typedef struct packed {
        logic [3:0] st;
        logic [9:0] len;
        logic       chk_rwn;
        logic       rwn;
    } seg_t;

    seg_t       init_q[$];
    seg_t       work_q[$];
    logic [1:0] ack_q[$];   // 1 = write ack, 2 = read ack
    int         total = 0;
    int         bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s: actual=timeout required=event", nm);
    endtask

    function automatic seg_t mk(input logic [3:0] st, input int len, input logic chk, input logic rwn);
        seg_t s;
        s.st = st; s.len = 10'(len); s.chk_rwn = chk; s.rwn = rwn;
        return s;
    endfunction

    task automatic push_init();
        init_q.push_back(mk(4'd0, 20, 1'b0, 1'b0));
        init_q.push_back(mk(4'd1, 1,  1'b0, 1'b0));
        init_q.push_back(mk(4'd2, 3,  1'b0, 1'b0));
        init_q.push_back(mk(4'd3, 1,  1'b0, 1'b0));
        init_q.push_back(mk(4'd4, 7,  1'b0, 1'b0));
        init_q.push_back(mk(4'd5, 1,  1'b0, 1'b0));
        init_q.push_back(mk(4'd6, 7,  1'b0, 1'b0));
        init_q.push_back(mk(4'd7, 1,  1'b0, 1'b0));
        init_q.push_back(mk(4'd8, 2,  1'b0, 1'b0));
    endtask

    task automatic push_write(input int len, input bit with_ack);
        work_q.push_back(mk(W_ACTIVE, 1, 1'b1, 1'b0));
        work_q.push_back(mk(W_TRCD,   3, 1'b1, 1'b0));
        work_q.push_back(mk(W_WRITE,  1, 1'b1, 1'b0));
        if (with_ack) begin
            work_q.push_back(mk(W_WD,   len, 1'b1, 1'b0));
            work_q.push_back(mk(W_TDAL, 3,   1'b1, 1'b0));
            ack_q.push_back(2'd1);
        end
    endtask

    task automatic push_read(input int len);
        work_q.push_back(mk(W_ACTIVE, 1,   1'b1, 1'b1));
        work_q.push_back(mk(W_TRCD,   3,   1'b1, 1'b1));
        work_q.push_back(mk(W_READ,   1,   1'b1, 1'b1));
        work_q.push_back(mk(W_CL,     3,   1'b1, 1'b1));
        work_q.push_back(mk(W_RD,     len, 1'b1, 1'b1));
        ack_q.push_back(2'd2);
    endtask

    task automatic push_ref();
        work_q.push_back(mk(W_AR,   1, 1'b0, 1'b0));
        work_q.push_back(mk(W_TRFC, 7, 1'b0, 1'b0));
    endtask

    // ---------------- monitor ----------------
    logic [3:0] m_init_prev, m_work_prev;
    int         m_ilen, m_wlen;
    logic [9:0] m_cnt_exp;
    logic       m_fresh = 1'b1;
    logic       m_seg_rwn;
    seg_t       m_e;
    logic [1:0] m_a;

    always @(negedge clk) begin
        if (rst) begin
            m_fresh = 1'b1;
        end else begin
            if (m_fresh) begin
                m_fresh     = 1'b0;
                m_init_prev = init_state;
                m_work_prev = work_state;
                m_ilen      = 1;
                m_wlen      = 1;
                m_cnt_exp   = 10'd0;
                m_seg_rwn   = sys_r_wn;
                check("first_init_state", init_state, 0);
            end else begin
                if (init_state != m_init_prev || work_state != m_work_prev)
                    m_cnt_exp = 10'd0;
                else if (m_cnt_exp != 10'h3FF)
                    m_cnt_exp = m_cnt_exp + 10'd1;
                if (init_state != m_init_prev) begin
                    if (init_q.size() == 0) begin
                        timeout("init_seg_unexpected");
                    end else begin
                        m_e = init_q.pop_front();
                        check("init_seg_state", m_init_prev, m_e.st);
                        check("init_seg_len", m_ilen, m_e.len);
                    end
                    m_init_prev = init_state;
                    m_ilen = 1;
                end else begin
                    m_ilen++;
                end
                if (work_state != m_work_prev) begin
                    if (m_work_prev != W_IDLE) begin
                        if (work_q.size() == 0) begin
                            timeout("work_seg_unexpected");
                        end else begin
                            m_e = work_q.pop_front();
                            check("work_seg_state", m_work_prev, m_e.st);
                            check("work_seg_len", m_wlen, m_e.len);
                            if (m_e.chk_rwn)
                                check("sys_r_wn", m_seg_rwn, m_e.rwn);
                        end
                    end
                    m_work_prev = work_state;
                    m_wlen = 1;
                end else begin
                    m_wlen++;
                end
                m_seg_rwn = sys_r_wn;
            end
            check("cnt_clk", cnt_clk, m_cnt_exp);
            if (sdram_wr_ack) begin
                if (ack_q.size() == 0) timeout("wr_ack_unexpected");
                else begin m_a = ack_q.pop_front(); check("ack_kind_wr", 1, m_a); end
            end
            if (sdram_rd_ack) begin
                if (ack_q.size() == 0) timeout("rd_ack_unexpected");
                else begin m_a = ack_q.pop_front(); check("ack_kind_rd", 2, m_a); end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic check_reset_vals();
        check("rst_init_state", init_state, 0);
        check("rst_work_state", work_state, 0);
        check("rst_cnt_clk", cnt_clk, 0);
        check("rst_sys_r_wn", sys_r_wn, 0);
        check("rst_wr_ack", sdram_wr_ack, 0);
        check("rst_rd_ack", sdram_rd_ack, 0);
        check("rst_init_done", sdram_init_done, 0);
        check("rst_busy", sdram_busy, 1);
    endtask

    // Cycle 1 is the first cycle after release; init occupies cycles 1..43.
    task automatic init_seq();
        int cyc = 0;
        push_init();
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals();
        rst = 1'b0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check("busy_during_init", sdram_busy, 1);
        end while (!sdram_init_done && cyc < 200);
        check("init_done_cycle", cyc, 44);
    endtask

    task automatic wait_state(input logic [3:0] st, input int bound, input string nm);
        int n = 0;
        while (work_state !== st) begin
            @(negedge clk);
            n++;
            if (n > bound) begin timeout(nm); return; end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(work_state == W_IDLE && !sdram_busy && sdram_init_done)) begin
            @(negedge clk);
            n++;
            if (n > 1000) begin timeout("wait_idle"); return; end
        end
    endtask

    task automatic wait_ack(input bit is_rd);
        int n = 0;
        while (!(is_rd ? sdram_rd_ack : sdram_wr_ack)) begin
            @(negedge clk);
            n++;
            if (n > 800) begin timeout(is_rd ? "wait_rd_ack" : "wait_wr_ack"); return; end
        end
    endtask

    task automatic sync_refresh();
        push_ref();
        wait_state(W_TRFC, 250, "wait_refresh");
        wait_state(W_IDLE, 20, "wait_refresh_end");
        check("busy_after_refresh", sdram_busy, 0);
    endtask

    task automatic do_txn(input bit is_rd, input logic [9:0] nbytes, input int exp_len);
        wait_idle();
        if (is_rd) begin
            push_read(exp_len);
            sdrd_byte = nbytes; sdram_rd_req = 1'b1;
        end else begin
            push_write(exp_len, 1'b1);
            sdwr_byte = nbytes; sdram_wr_req = 1'b1;
        end
        @(negedge clk);
        check("busy_in_txn", sdram_busy, 1);
        wait_ack(is_rd);
        sdram_wr_req = 1'b0;
        sdram_rd_req = 1'b0;
    endtask

    initial begin
        sdram_wr_req = 1'b0; sdram_rd_req = 1'b0;
        sdwr_byte = 10'd0;   sdrd_byte = 10'd0;

        init_seq();
        sync_refresh();

        do_txn(1'b0, 10'd8, 8);
        do_txn(1'b1, 10'd4, 4);
        sync_refresh();

        // simultaneous requests: write first, then read
        wait_idle();
        push_write(8, 1'b1);
        push_read(4);
        sdwr_byte = 10'd8; sdrd_byte = 10'd4;
        sdram_wr_req = 1'b1; sdram_rd_req = 1'b1;
        wait_ack(1'b0);
        sdram_wr_req = 1'b0;
        wait_ack(1'b1);
        sdram_rd_req = 1'b0;
        sync_refresh();

        // 256-byte write spans refresh wraps; length changes mid-burst are ignored
        wait_idle();
        push_write(256, 1'b1);
        push_ref();
        push_read(4);
        sdwr_byte = 10'd256; sdram_wr_req = 1'b1;
        wait_state(W_WD, 20, "wait_wd_256");
        sdwr_byte = 10'd3; sdram_wr_req = 1'b0;
        sdrd_byte = 10'd4; sdram_rd_req = 1'b1;
        wait_ack(1'b0);
        wait_ack(1'b1);
        sdram_rd_req = 1'b0;
        sync_refresh();

        // length clamping: 0 -> 1, 700 -> 256
        do_txn(1'b0, 10'd0, 1);
        do_txn(1'b1, 10'd700, 256);
        sync_refresh();
        sync_refresh();

        // reset during W_WD aborts with no ack and replays init
        wait_idle();
        push_write(8, 1'b0);
        sdwr_byte = 10'd8; sdram_wr_req = 1'b1;
        wait_state(W_WD, 20, "wait_wd_rst");
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
        sdram_wr_req = 1'b0;
        #1;
        check_reset_vals();
        init_seq();

        do_txn(1'b0, 10'd8, 8);
        repeat (3) @(negedge clk);

        check("init_q_empty", init_q.size(), 0);
        check("work_q_empty", work_q.size(), 0);
        check("ack_q_empty", ack_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdram_ctrl_fsm.md
SDRAM_CTRL_FSM -- requirements
Module: sdram_ctrl_fsm

Parameters (one per line: name, default, meaning)
REQ-001 The block SHALL have parameter T_INIT, 10000: power-up wait in clk cycles (200 us at 50 MHz).
REQ-002 The block SHALL have parameters TRP=3, TRFC=7, TMRD=2, TRCD=3, TCL=3 and TDAL=3: the hold time in cycles of the states of the same name.
REQ-003 The block SHALL have parameter REF_PERIOD, 750: auto-refresh interval in cycles (15 us).

Interface (one per line: name, direction, width, meaning)
REQ-004 The block SHALL have port clk, input, 1: 50 MHz clock, the single clock.
REQ-005 The block SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 The block SHALL have ports sdram_wr_req and sdram_rd_req, input, 1 each: level requests for a burst write or a burst read.
REQ-007 The block SHALL have ports sdwr_byte and sdrd_byte, input, 10 each: burst lengths 1-256, sampled in W_IDLE.
REQ-008 The block SHALL have ports sdram_wr_ack and sdram_rd_ack, output, 1 each: one-cycle completion pulses.
REQ-009 The block SHALL have port init_state, output, 4: init FSM code.
REQ-010 The block SHALL have port work_state, output, 4: work FSM code.
REQ-011 The block SHALL have port sys_r_wn, output, 1: 1 = read transaction, 0 = write.
REQ-012 The block SHALL have port cnt_clk, output, 10: cycles spent in the current state.
REQ-013 The block SHALL have ports sdram_init_done and sdram_busy, output, 1 each.

Function
REQ-014 init_state SHALL use these encodings: I_NOP=0, I_PRE=1, I_TRP=2, I_AR1=3, I_TRF1=4, I_AR2=5, I_TRF2=6, I_MRS=7, I_TMRD=8, I_DONE=9.
REQ-015 work_state SHALL use these encodings: W_IDLE=0, W_ACTIVE=1, W_TRCD=2, W_READ=3, W_CL=4, W_RD=5, W_WRITE=6, W_WD=7, W_TDAL=8, W_AR=9, W_TRFC=10.
REQ-016 cnt_clk SHALL clear to 0 on the cycle after any init_state or work_state change, otherwise increment, and saturate at 1023.
REQ-017 The init FSM SHALL follow: I_NOP (T_INIT cycles, own 14-bit counter) -> I_PRE (1) -> I_TRP (TRP) -> I_AR1 (1) -> I_TRF1 (TRFC) -> I_AR2 (1) -> I_TRF2 (TRFC) -> I_MRS (1) -> I_TMRD (TMRD) -> I_DONE, where I_DONE is terminal until reset.
REQ-018 A timed state with hold N SHALL exit on the cycle where cnt_clk == N-1.
REQ-019 The work FSM SHALL stay in W_IDLE while init_state != I_DONE.
REQ-020 The W_IDLE decision priority SHALL be: pending refresh -> W_AR; else sdram_wr_req -> W_ACTIVE with sys_r_wn=0; else sdram_rd_req -> W_ACTIVE with sys_r_wn=1.
REQ-021 sys_r_wn SHALL hold its value outside W_IDLE.
REQ-022 The work FSM SHALL step W_ACTIVE (1) -> W_TRCD (TRCD) -> W_WRITE or W_READ (1), choosing W_READ when sys_r_wn=1.
REQ-023 The write path SHALL step W_WRITE -> W_WD (sdwr_byte cycles) -> W_TDAL (TDAL) -> W_IDLE.
REQ-024 The read path SHALL step W_READ -> W_CL (TCL) -> W_RD (sdrd_byte cycles) -> W_IDLE.
REQ-025 W_AR SHALL last 1 cycle, then W_TRFC (TRFC), then W_IDLE.
REQ-026 The burst length SHALL be latched in W_IDLE when the transaction starts, so that later changes to sdwr_byte or sdrd_byte have no effect on that burst.
REQ-027 A latched length of 0 SHALL be treated as 1, and values above 256 SHALL be clamped to 256.
REQ-028 The refresh counter SHALL run only after init done, count modulo REF_PERIOD, and set ref_pending at wrap.
REQ-029 ref_pending SHALL clear on entry to W_AR.
REQ-030 A wrap occurring during a burst SHALL be serviced at the next W_IDLE, ahead of any requests.
REQ-031 sdram_wr_ack SHALL pulse for the single cycle in which W_TDAL exits.
REQ-032 sdram_rd_ack SHALL pulse for the single cycle in which W_RD exits.
REQ-033 sdram_init_done SHALL equal (init_state == I_DONE).
REQ-034 sdram_busy SHALL be 1 unless init is done AND work_state == W_IDLE AND no refresh is pending.
REQ-035 When requests are deasserted mid-transaction, the transaction SHALL complete anyway.
REQ-036 When wr_req and rd_req arrive simultaneously, the write SHALL be served first and the read on the next W_IDLE.

Reset
REQ-037 On rst high, the block SHALL asynchronously set init_state=I_NOP, work_state=W_IDLE, cnt_clk=0, sys_r_wn=0, both acks=0, sdram_init_done=0, sdram_busy=1, and clear ref_pending, the refresh counter and the T_INIT counter.
REQ-038 Reset asserted mid-burst SHALL abort the transaction with no ack, and initialization SHALL restart from I_NOP after release.

Verification (T_INIT=20 and REF_PERIOD=100 overridden)
REQ-039 Scenario: release rst with no requests -> init_state visits 0..9 in order; I_NOP lasts 20 cycles, I_TRP 3, each I_TRF 7, I_TMRD 2; sdram_init_done rises at cycle 44.
REQ-040 Scenario: wr_req with sdwr_byte=8 after init -> work_state visits 1, 2 (3 cycles), 6, 7 (8 cycles), 8 (3 cycles), 0; sys_r_wn=0; a single sdram_wr_ack pulse.
REQ-041 Scenario: rd_req with sdrd_byte=4 -> work_state visits 1, 2, 3, 4 (3 cycles), 5 (4 cycles), 0; sys_r_wn=1; a single sdram_rd_ack pulse.
REQ-042 Scenario: wr_req and rd_req asserted in the same cycle -> full write (wr_ack), then full read (rd_ack).
REQ-043 Scenario: refresh wrap during a 256-byte write -> write completes, then W_AR, then W_TRFC (7 cycles), then a pending read proceeds.
REQ-044 Scenario: rst pulsed during W_WD -> all outputs at reset values immediately, no ack, and the init sequence replays.
